// File: rtl/spi_host_loader_pkg.sv
// Shared opcodes, select codes, state encoding and frame layout for the serial load/run host driver.
package spi_host_loader_pkg;

    localparam int unsigned FRAME_W   = 12;
    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_LOAD_I = 2'b01,
        OP_LOAD_D = 2'b10,
        OP_RUN    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SEL_IDLE = 2'b00,
        SEL_CSI  = 2'b01,
        SEL_CSD  = 2'b10,
        SEL_RUN  = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10,
        ST_RUN   = 2'b11
    } state_e;

    // Shifted LSB-first, so the slave ends up with addr in [3:0] and data in [11:4].
    typedef struct packed {
        logic [7:0] data;
        logic [3:0] addr;
    } frame_t;

endpackage

// File: rtl/spi_host_loader_sync_2ff.sv
// Two-flop synchroniser for the processor's done line.
module spi_host_loader_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_host_loader.sv
// Host-side driver for the processor's serial load/run port: shifts 12-bit load frames
// and supervises a run until done or timeout.
module spi_host_loader
    import spi_host_loader_pkg::*;
#(
    parameter int unsigned           GAP_CYCLES   = 1,
    parameter int unsigned           GUARD_CYCLES = 4,
    parameter int unsigned           TIMEOUT_W    = 16,
    parameter logic [TIMEOUT_W-1:0]  TIMEOUT_MAX  = TIMEOUT_W'(16'hFFFF)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic       done_in,
    output logic [1:0] sel_out,
    output logic       mosi_out,
    output logic       busy,
    output logic       run_done,
    output logic       run_timeout
);

    localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GUARD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

    state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [GUARD_W-1:0]     guard_cnt_q, guard_cnt_d;
    logic [TIMEOUT_W-1:0]   tmo_cnt_q, tmo_cnt_d, tmo_inc;
    frame_t                 frame_q, frame_d;
    logic [1:0]             cs_q, cs_d;
    logic [FRAME_W-1:0]     frame_bits;
    logic                   done_sync;
    logic                   done_hit;

    logic [1:0]             sel_d;
    logic                   mosi_d, ready_d, busy_d, run_done_d, run_timeout_d;

    spi_host_loader_sync_2ff u_done_sync (
        .clk (clk),
        .rst (rst),
        .d   (done_in),
        .q   (done_sync)
    );

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            guard_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            frame_q     <= '0;
            cs_q        <= SEL_IDLE;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            frame_q     <= frame_d;
            cs_q        <= cs_d;
        end
    end

    // Next state, counters, and the output values the next state will present.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        guard_cnt_d   = guard_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        frame_d       = frame_q;
        cs_d          = cs_q;
        run_done_d    = 1'b0;
        run_timeout_d = 1'b0;
        tmo_inc       = (tmo_cnt_q == TIMEOUT_MAX) ? tmo_cnt_q : tmo_cnt_q + TIMEOUT_W'(1);
        done_hit      = (guard_cnt_q == GUARD_W'(GUARD_CYCLES)) && done_sync;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    unique case (cmd_op)
                        OP_LOAD_I, OP_LOAD_D: begin
                            frame_d.data = cmd_data;
                            frame_d.addr = cmd_addr;
                            cs_d         = (cmd_op == OP_LOAD_I) ? SEL_CSI : SEL_CSD;
                            bit_cnt_d    = '0;
                            state_d      = ST_SHIFT;
                        end
                        OP_RUN: begin
                            guard_cnt_d = '0;
                            tmo_cnt_d   = '0;
                            state_d     = ST_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == BIT_CNT_W'(FRAME_W - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    bit_cnt_d   = '0;
                    gap_cnt_d   = '0;
                    guard_cnt_d = '0;
                    tmo_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_RUN: begin
                tmo_cnt_d = tmo_inc;
                if (guard_cnt_q != GUARD_W'(GUARD_CYCLES)) begin
                    guard_cnt_d = guard_cnt_q + GUARD_W'(1);
                end
                // Done takes priority over a simultaneous timeout.
                if (done_hit) begin
                    run_done_d = 1'b1;
                    gap_cnt_d  = '0;
                    state_d    = ST_GAP;
                end else if (tmo_inc == TIMEOUT_MAX) begin
                    run_timeout_d = 1'b1;
                    gap_cnt_d     = '0;
                    state_d       = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        frame_bits = frame_d;
        sel_d      = SEL_IDLE;
        mosi_d     = 1'b0;
        unique case (state_d)
            ST_SHIFT: begin
                sel_d  = cs_d;
                mosi_d = frame_bits[bit_cnt_d];
            end
            ST_RUN:  sel_d = SEL_RUN;
            default: sel_d = SEL_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_out     <= SEL_IDLE;
            mosi_out    <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            run_timeout <= 1'b0;
        end else begin
            sel_out     <= sel_d;
            mosi_out    <= mosi_d;
            cmd_ready   <= ready_d;
            busy        <= busy_d;
            run_done    <= run_done_d;
            run_timeout <= run_timeout_d;
        end
    end

endmodule

// File: tb/tb_spi_host_loader.sv
// Bench for spi_host_loader: queue-based expected-output model, a slave/cache model, directed and random traffic.
module tb_spi_host_loader;
    import spi_host_loader_pkg::*;

    localparam int unsigned GAP_C   = 1;
    localparam int unsigned GUARD_C = 4;
    localparam int unsigned TMAX    = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       done_in;
    logic [1:0] sel_out;
    logic       mosi_out;
    logic       busy;
    logic       run_done;
    logic       run_timeout;

    int n_vec = 0;
    int n_err = 0;

    spi_host_loader #(
        .GAP_CYCLES   (GAP_C),
        .GUARD_CYCLES (GUARD_C),
        .TIMEOUT_W    (16),
        .TIMEOUT_MAX  (16'(TMAX))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .done_in     (done_in),
        .sel_out     (sel_out),
        .mosi_out    (mosi_out),
        .busy        (busy),
        .run_done    (run_done),
        .run_timeout (run_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic       mosi;
        logic       busy;
        logic       ready;
        logic       rd;
        logic       rt;
    } exp_t;

    // Expected outputs: every accepted transaction expands into a list of output cycles.
    exp_t e;
    exp_t q[$];
    bit   in_run = 1'b0;
    int   run_n = 0;
    logic m1 = 1'b0, m2 = 1'b0;
    bit   mdl_started = 1'b0;

    always @(posedge clk) begin : model
        logic        ds;
        logic [11:0] fr;
        logic        end_rd, end_rt;
        ds = m2;
        m2 = m1;
        m1 = done_in;
        mdl_started = 1'b1;
        end_rd = 1'b0;
        end_rt = 1'b0;
        if (rst) begin
            q.delete();
            in_run = 1'b0;
            run_n  = 0;
            m1 = 1'b0;
            m2 = 1'b0;
            e = '{sel: 2'b00, mosi: 1'b0, busy: 1'b0, ready: 1'b0, rd: 1'b0, rt: 1'b0};
        end else begin
            if (in_run) begin
                run_n++;
                if (run_n > int'(GUARD_C) && ds) end_rd = 1'b1;
                else if (run_n >= int'(TMAX))   end_rt = 1'b1;
                if (end_rd || end_rt) begin
                    in_run = 1'b0;
                    for (int g = 0; g < int'(GAP_C); g++)
                        q.push_back('{sel: 2'b00, mosi: 1'b0, busy: 1'b1, ready: 1'b0,
                                      rd: (g == 0) && end_rd, rt: (g == 0) && end_rt});
                end
            end else if (q.size() == 0 && e.ready && cmd_valid) begin
                fr = {cmd_data, cmd_addr};
                if (cmd_op == OP_LOAD_I || cmd_op == OP_LOAD_D) begin
                    for (int k = 0; k < 12; k++)
                        q.push_back('{sel: (cmd_op == OP_LOAD_I) ? 2'b01 : 2'b10, mosi: fr[k],
                                      busy: 1'b1, ready: 1'b0, rd: 1'b0, rt: 1'b0});
                    for (int g = 0; g < int'(GAP_C); g++)
                        q.push_back('{sel: 2'b00, mosi: 1'b0, busy: 1'b1, ready: 1'b0, rd: 1'b0, rt: 1'b0});
                end else if (cmd_op == OP_RUN) begin
                    in_run = 1'b1;
                    run_n  = 0;
                end
            end
            if (in_run)
                e = '{sel: 2'b11, mosi: 1'b0, busy: 1'b1, ready: 1'b0, rd: 1'b0, rt: 1'b0};
            else if (q.size() != 0)
                e = q.pop_front();
            else
                e = '{sel: 2'b00, mosi: 1'b0, busy: 1'b0, ready: 1'b1, rd: 1'b0, rt: 1'b0};
        end
    end

    // Slave model and select-run monitor.
    logic [1:0]  prev_sel = 2'b00;
    int          run_len = 0;
    int          last_len = 0;
    logic [11:0] cap = '0;
    logic [7:0]  icache [16];
    logic [7:0]  dcache [8];
    int          rd_cnt = 0;
    int          rt_cnt = 0;

    always @(negedge clk) begin
        if (sel_out != prev_sel) begin
            if (prev_sel != 2'b00) last_len = run_len;
            if (sel_out == 2'b00 && prev_sel == 2'b01) icache[cap[3:0]] = cap[11:4];
            if (sel_out == 2'b00 && prev_sel == 2'b10 && !cap[3]) dcache[cap[2:0]] = cap[11:4];
            run_len = 0;
        end
        if (sel_out != 2'b00) run_len++;
        if (sel_out == 2'b01 || sel_out == 2'b10) cap = {mosi_out, cap[11:1]};
        if (run_done)    rd_cnt++;
        if (run_timeout) rt_cnt++;
        prev_sel = sel_out;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    int done_mode = 2;
    int exec_len  = 9;

    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic release_cmd();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(cmd_ready && !busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(cmd_ready && !busy), 32'd1);
    endtask

    initial begin
        int rd0, rt0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0; done_in = 1'b1;
        fork
            begin : done_driver
                int run_cyc;
                run_cyc = 0;
                forever begin
                    @(negedge clk);
                    if (sel_out == 2'b11) run_cyc++; else run_cyc = 0;
                    case (done_mode)
                        0:       done_in = (sel_out != 2'b11) || (run_cyc < 2) || (run_cyc >= exec_len);
                        1:       done_in = 1'b0;
                        2:       done_in = 1'b1;
                        default: done_in = ($urandom_range(0, 5) == 0);
                    endcase
                end
            end
            begin : compare
                forever begin
                    @(negedge clk);
                    if (mdl_started)
                        chk("outputs", 32'({sel_out, mosi_out, busy, cmd_ready, run_done, run_timeout}), 32'(e));
                end
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single instruction load.
        send(OP_LOAD_I, 4'h3, 8'hA5);
        release_cmd();
        wait_idle();
        chk("t1_cs_len", 32'(last_len), 32'd12);
        chk("t1_mosi_bits", 32'(cap), 32'hA53);
        chk("t1_icache3", 32'(icache[3]), 32'hA5);

        // Back-to-back data loads with valid held.
        send(OP_LOAD_D, 4'h2, 8'h7F);
        send(OP_LOAD_D, 4'h5, 8'h80);
        release_cmd();
        wait_idle();
        chk("t2_dcache2", 32'(dcache[2]), 32'h7F);
        chk("t2_dcache5", 32'(dcache[5]), 32'h80);

        // Program load then run to done.
        send(OP_LOAD_I, 4'hD, 8'h11);
        send(OP_LOAD_I, 4'hE, 8'h22);
        send(OP_LOAD_I, 4'hF, 8'h33);
        release_cmd();
        wait_idle();
        chk("t3_icacheF", 32'(icache[15]), 32'h33);
        done_mode = 0; exec_len = 9;
        rd0 = rd_cnt; rt0 = rt_cnt;
        send(OP_RUN, 4'h0, 8'h00);
        release_cmd();
        wait_idle();
        chk("t3_run_len", 32'(last_len), 32'd11);
        chk("t3_run_done", 32'(rd_cnt - rd0), 32'd1);
        chk("t3_no_timeout", 32'(rt_cnt - rt0), 32'd0);

        // Run with done stuck low: timeout.
        done_mode = 1;
        rd0 = rd_cnt; rt0 = rt_cnt;
        send(OP_RUN, 4'h0, 8'h00);
        release_cmd();
        wait_idle();
        chk("t4_run_len", 32'(last_len), 32'(TMAX));
        chk("t4_no_done", 32'(rd_cnt - rd0), 32'd0);
        chk("t4_timeout", 32'(rt_cnt - rt0), 32'd1);

        // Run with done stuck high: ends right at guard expiry.
        done_mode = 2;
        rd0 = rd_cnt; rt0 = rt_cnt;
        send(OP_RUN, 4'h0, 8'h00);
        release_cmd();
        wait_idle();
        chk("t5_run_len", 32'(last_len), 32'd5);
        chk("t5_run_done", 32'(rd_cnt - rd0), 32'd1);
        chk("t5_no_timeout", 32'(rt_cnt - rt0), 32'd0);

        // Reset in the sixth shift cycle, then a clean reload.
        send(OP_LOAD_I, 4'h9, 8'h3C);
        release_cmd();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_sel", 32'(sel_out), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        send(OP_LOAD_I, 4'h9, 8'h3C);
        release_cmd();
        wait_idle();
        chk("t6_icache9", 32'(icache[9]), 32'h3C);
        chk("t6_cs_len", 32'(last_len), 32'd12);

        // Random traffic including NOPs, bad data addresses, random done and stray resets.
        for (int it = 0; it < 60; it++) begin
            done_mode = $urandom_range(0, 3);
            exec_len  = $urandom_range(3, 15);
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            release_cmd();
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 14)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_host_loader.md
Name: spi_host_loader

Overview:
- Master-side driver for the tiny processor's serial load/run port. It drives the processor's uio_in[2:0]: a 2-bit select code and MOSI.
- Turns host commands into slave transactions:
  - load instruction word (12-bit frame);
  - load data word (12-bit frame);
  - run to completion, then wait for the processor's done output.
- Used on the FPGA demo board and as the stimulus driver in the processor testbench.

Parameters:
- GAP_CYCLES, 1, cycles of select code 00 after each frame and after each run (minimum 1).
- GUARD_CYCLES, 4, cycles after run assertion during which synchronised done is ignored.
- TIMEOUT_W, 16, width of the run timeout counter.
- TIMEOUT_MAX, 16'hFFFF, run cycles before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high when a command can be accepted.
- cmd_op  in  2  command: 00 NOP, 01 LOAD_I, 10 LOAD_D, 11 RUN.
- cmd_addr  in  4  target cache address (LOAD_D uses only 0..7).
- cmd_data  in  8  word to write.
- done_in  in  1  processor done (uio_out[3]); asynchronous to this block.
- sel_out  out  2  to processor uio_in[1:0]: 00 idle, 01 instruction chip-select, 10 data chip-select, 11 run enable.
- mosi_out  out  1  to processor uio_in[2].
- busy  out  1  high in every state except IDLE.
- run_done  out  1  one-cycle pulse when a run ends by done.
- run_timeout  out  1  one-cycle pulse when a run is aborted by timeout.

Behaviour:
- All outputs are registered.
- Reset values: sel_out=00, mosi_out=0, cmd_ready=0 (it rises the cycle after reset deasserts), busy=0, run_done=0, run_timeout=0. State = IDLE, all counters = 0.
- States: IDLE, SHIFT, GAP, RUN.
- IDLE:
  - sel_out=00, cmd_ready=1.
  - A command is accepted on cmd_valid & cmd_ready; cmd_ready drops the next cycle.
  - NOP is accepted and dropped; the block stays in IDLE.
- Frame format: frame = {cmd_data, cmd_addr}, 12 bits, sent LSB-first.
  - Bit 0 (addr[0]) goes first; bit 11 (data[7]) goes last.
  - The slave's shift register then holds addr in [3:0] and data in [11:4].
- SHIFT:
  - Entered from LOAD_I or LOAD_D.
  - sel_out = 01 (LOAD_I) or 10 (LOAD_D), held for exactly 12 consecutive cycles.
  - mosi_out = frame[k] on the k-th such cycle; a 4-bit bit counter runs 0..11.
  - After cycle 11 go to GAP.
  - The select code never changes directly from one chip-select code to another.
- GAP:
  - sel_out=00, mosi_out=0 for GAP_CYCLES cycles.
  - The slave commits the frame on the first GAP cycle.
  - Then go to IDLE.
- RUN:
  - sel_out=11.
  - done_in passes through a 2-flop synchroniser.
  - Guard counter: synchronised done is ignored for the first GUARD_CYCLES cycles. The slave's done stays high until it enters EXEC, and the synchroniser adds 2 cycles of latency.
  - After the guard, the first cycle with synchronised done = 1: sel_out=00 next cycle, run_done pulses, go to GAP.
  - Timeout counter increments each RUN cycle. When it reaches TIMEOUT_MAX: sel_out=00, run_timeout pulses, go to GAP.
  - If done and timeout occur in the same cycle, done wins: run_done pulses, run_timeout does not.
- Counters clear on entry to each state. The timeout counter saturates and never wraps.
- Reset mid-operation: the state machine returns to IDLE and sel_out=00 at the next edge.
  - A partial frame may then be committed by the slave. Callers must reset the slave together with this block.
- LOAD_D with cmd_addr[3]=1 is sent unchanged; the slave ignores it. No error is raised.

Decomposition:
- Shared package: opcode constants (NOP/LOAD_I/LOAD_D/RUN), select codes (SEL_IDLE=00, SEL_CSI=01, SEL_CSD=10, SEL_RUN=11), FRAME_W=12, state encoding.
- One sub-module: sync_2ff (2-flop synchroniser for done_in).

Test Plan:
1. LOAD_I addr=4'h3 data=8'hA5:
   - sel_out=01 for 12 cycles.
   - mosi sequence 1,1,0,0,1,0,1,0,0,1,0,1.
   - Then 00 for 1 cycle.
   - Processor icache[3]=8'hA5.
2. Back-to-back LOAD_D addr=2 data=8'h7F, then LOAD_D addr=5 data=8'h80 (cmd_valid held):
   - At least one 00 cycle between frames.
   - dcache[2]=8'h7F, dcache[5]=8'h80.
3. Load a 3-instruction program ending at pc=15, then RUN:
   - sel_out=11.
   - run_done pulses after done rises, with synchroniser latency.
   - sel_out returns to 00; dcache holds the expected result.
4. RUN with done_in forced low and TIMEOUT_MAX=16'd20:
   - run_timeout pulses after 20 RUN cycles; run_done stays 0; sel_out=00.
5. RUN with done_in held high throughout:
   - No run_done during the first 4 cycles.
   - run_done pulses on guard expiry (cycle 5).
6. Assert rst on SHIFT cycle 6:
   - Next edge: sel_out=00, busy=0.
   - After reset release, a new LOAD_I is accepted and completes normally.
